dl_rom_writer: RTL

Bridge between the `data_io` download stream and the two SDRAM write ports (`port1`: main CPU ROM, `port2`: sound ROM) in the `clk_mem` domain. It captures byte writes for one `ioctl_index`, buffers them in a small FIFO and replays each byte as a toggle request/acknowledge transaction. Each byte goes to port1, and also to port2 when it falls in the sound-ROM region. It also produces the `rom_loaded` flag and a completion pulse for core reset gating.

---
 rtl/dl_rom_writer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dl_rom_writer.sv
// dl_rom_writer: captures data_io download bytes into a small FIFO and
// replays them to the SDRAM ROM write ports via toggle req/ack handshakes.
module dl_rom_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DL_INDEX   = 8'h00,
  parameter logic [24:0] SND_BASE   = 25'h7400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        busy,
  output logic        overflow,
  output logic        done,
  output logic        rom_loaded
);

  localparam int unsigned AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic          acc, acc_q, wr_q;
  logic          acc_rise, acc_fall;
  logic          push_req, push, drop, pop;
  logic          full, empty;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [23:0]   head_addr;
  logic [7:0]    head_data;
  logic          head_snd;
  logic          got, pending, p2, ack_ok, we;
  logic          unused_addr_msb;

  // bit 24 of the download address does not reach the SDRAM
  assign unused_addr_msb = ioctl_addr[24];

  assign acc      = ioctl_downl & (ioctl_index == DL_INDEX);
  assign acc_rise = acc & ~acc_q;
  assign acc_fall = ~acc & acc_q;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = acc & ioctl_wr & ~wr_q;
  assign push     = push_req & ~full;
  assign drop     = push_req & full;

  assign {head_addr, head_data} = mem[rptr];
  assign head_snd = (head_addr >= SND_BASE[23:0]);

  assign ack_ok = (port1_ack == port1_req) &
                  (~p2 | (port2_ack == port2_req));
  assign busy     = ~empty | (state == WAIT);
  assign port1_we = we;
  assign port2_we = we;

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wptr] <= {ioctl_addr[23:0], ioctl_dout};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push)
        count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= 1'b0;
      wr_q       <= 1'b0;
      overflow   <= 1'b0;
      got        <= 1'b0;
      pending    <= 1'b0;
      we         <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      acc_q <= acc;
      wr_q  <= ioctl_wr;
      if (acc_rise)
        overflow <= drop;
      else if (drop)
        overflow <= 1'b1;
      if (acc_rise)
        got <= push;
      else if (acc_fall)
        got <= 1'b0;
      else if (push)
        got <= 1'b1;
      if (state == FLUSH)
        pending <= 1'b0;
      if (acc_fall && got)
        pending <= 1'b1;
      if (acc_rise)
        we <= 1'b1;
      else if (state == FLUSH)
        we <= 1'b0;
      if (acc_rise)
        rom_loaded <= 1'b0;
      else if (state == FLUSH)
        rom_loaded <= 1'b1;
    end
  end

  // req follows ack on reset so no request is left hanging
  always_ff @(posedge clk) begin
    if (reset) begin
      port1_req <= port1_ack;
      port2_req <= port2_ack;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      p2        <= 1'b0;
    end else if (pop) begin
      port1_a   <= head_addr[23:1];
      port1_ds  <= {head_addr[0], ~head_addr[0]};
      port1_d   <= {head_data, head_data};
      port2_a   <= head_addr[23:1] - SND_BASE[23:1];
      port2_ds  <= {head_addr[0], ~head_addr[0]};
      port2_d   <= {head_data, head_data};
      port1_req <= ~port1_req;
      p2        <= head_snd;
      if (head_snd)
        port2_req <= ~port2_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = WAIT;
        end else if (pending) begin
          state_nx = FLUSH;
        end
      end
      WAIT: begin
        if (ack_ok)
          state_nx = IDLE;
      end
      FLUSH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
